// File: rtl/regfile_pkg.sv
// Shared types and constants for the regfile writeback path.
package regfile_pkg;

   localparam int DATA_W = 64;
   localparam int ADDR_W = 5;

   // Register 31 reads as zero; writes to it are discarded.
   localparam logic [ADDR_W-1:0] XZR = 5'd31;

   typedef struct packed {
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Two-write / one-read circular FIFO of writeback entries.
// Storage and occupancy mask are exported so the top level can forward from them.
module wb_fifo
   import regfile_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       push_n,
   input  wb_entry_t        push0,
   input  wb_entry_t        push1,
   output wb_entry_t        entries [DEPTH],
   output logic [DEPTH-1:0] valid,
   output logic [PTR_W-1:0] head,
   output logic [CNT_W-1:0] count
);

   logic [PTR_W-1:0] tail;
   logic             pop;

   // A write retires every cycle the queue holds anything.
   assign pop = (count != '0);

   // Pointer and occupancy update; push0 is always the older of two pushes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         // NOTE: state registers use <= so every block samples pre-edge values.
         if (pop) head <= head + PTR_W'(1);
         tail  <= tail + PTR_W'(push_n);
         count <= count + CNT_W'(push_n) - CNT_W'(pop);
      end
   end

   // Entry storage written at tail / tail+1.
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; the valid mask and count gate every read of it.
      if (push_n != 2'd0) entries[tail] <= push0;
      if (push_n == 2'd2) entries[tail + PTR_W'(1)] <= push1;
   end

   // An entry is occupied when its age relative to head is below count.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         valid[i] = CNT_W'(PTR_W'(i) - head) < count;
      end
   end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Write scheduler between MEM/WB and the register file: filters XZR writes,
// queues up to two results per cycle, retires one per cycle and forwards
// queued data to both read ports.
module regfile_write_scheduler
   import regfile_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              alu_valid,
   input  logic [ADDR_W-1:0] alu_rd,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              ld_valid,
   input  logic [ADDR_W-1:0] ld_rd,
   input  logic [DATA_W-1:0] ld_data,
   output logic              stall,
   output logic              RegWrite,
   output logic [ADDR_W-1:0] WriteRegister,
   output logic [DATA_W-1:0] WriteData,
   input  logic [ADDR_W-1:0] ReadRegister1,
   input  logic [ADDR_W-1:0] ReadRegister2,
   output logic              fwd_hit1,
   output logic [DATA_W-1:0] fwd_data1,
   output logic              fwd_hit2,
   output logic [DATA_W-1:0] fwd_data2,
   output logic [CNT_W-1:0]  count
);

   wb_entry_t        entries [DEPTH];
   logic [DEPTH-1:0] valid;
   logic [PTR_W-1:0] head;
   logic             acc_alu;
   logic             acc_ld;
   logic [1:0]       push_n;
   wb_entry_t        push0;
   wb_entry_t        push1;

   // Fewer than two free slots blocks all requests; the same-cycle pop is not credited.
   assign stall = count > CNT_W'(DEPTH - 2);

   assign acc_alu = !stall && alu_valid && (alu_rd != XZR);
   assign acc_ld  = !stall && ld_valid  && (ld_rd  != XZR);
   assign push_n  = {1'b0, acc_alu} + {1'b0, acc_ld};

   // ALU result is older, so it takes the first slot whenever it is accepted.
   assign push0 = acc_alu ? wb_entry_t'{rd: alu_rd, data: alu_data}
                          : wb_entry_t'{rd: ld_rd,  data: ld_data};
   assign push1 = wb_entry_t'{rd: ld_rd, data: ld_data};

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (reset),
      .push_n  (push_n),
      .push0   (push0),
      .push1   (push1),
      .entries (entries),
      .valid   (valid),
      .head    (head),
      .count   (count)
   );

   // Write port presents the head entry, zero when empty.
   assign RegWrite      = (count != '0);
   assign WriteRegister = RegWrite ? entries[head].rd   : '0;
   assign WriteData     = RegWrite ? entries[head].data : '0;

   // Walk oldest to youngest so the youngest matching entry overrides older ones.
   function automatic logic [DATA_W:0] fwd_lookup(input logic [ADDR_W-1:0] rr);
      logic [DATA_W:0]  res;
      logic [PTR_W-1:0] idx;
      res = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head + PTR_W'(k);
         if (rr != XZR && valid[idx] && entries[idx].rd == rr) begin
            res = {1'b1, entries[idx].data};
         end
      end
      return res;
   endfunction

   // Forwarding comparators for both read ports.
   always_comb begin
      // NOTE: default every output first so no path leaves one unassigned (no latch).
      fwd_hit1  = 1'b0;
      fwd_data1 = '0;
      fwd_hit2  = 1'b0;
      fwd_data2 = '0;
      {fwd_hit1, fwd_data1} = fwd_lookup(ReadRegister1);
      {fwd_hit2, fwd_data2} = fwd_lookup(ReadRegister2);
   end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Scoreboard bench for regfile_write_scheduler with a behavioural regfile.
module tb_regfile_write_scheduler;
   import regfile_pkg::*;

   logic              clk = 1'b0;
   logic              reset;
   logic              alu_valid, ld_valid;
   logic [ADDR_W-1:0] alu_rd, ld_rd;
   logic [DATA_W-1:0] alu_data, ld_data;
   logic              stall, RegWrite;
   logic [ADDR_W-1:0] WriteRegister;
   logic [DATA_W-1:0] WriteData;
   logic [ADDR_W-1:0] ReadRegister1, ReadRegister2;
   logic              fwd_hit1, fwd_hit2;
   logic [DATA_W-1:0] fwd_data1, fwd_data2;
   logic [2:0]        count;

   regfile_write_scheduler #(.DEPTH(4)) dut (
      .clk(clk), .reset(reset),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
      .stall(stall), .RegWrite(RegWrite),
      .WriteRegister(WriteRegister), .WriteData(WriteData),
      .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
      .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
      .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
      .count(count)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          mc       = 0;   // model occupancy
   wb_entry_t   sb[$];          // expected commit order
   wb_entry_t   got;
   logic [DATA_W-1:0] rf [32];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Behavioural regfile: commits on the edge that retires the head entry.
   always @(posedge clk) begin
      if (!reset && RegWrite && WriteRegister != XZR) rf[WriteRegister] <= WriteData;
   end

   // Every cycle the write port is active must match the next scoreboard entry.
   always @(negedge clk) begin
      if (!reset && RegWrite) begin
         if (sb.size() == 0) check("spurious_write", 64'(WriteRegister), 64'hFFFF);
         else begin
            got = sb.pop_front();
            check("wr_rd",   64'(WriteRegister), 64'(got.rd));
            check("wr_data", WriteData, got.data);
         end
      end
   end

   task automatic tick(input int acc_n);
      @(posedge clk);
      mc = mc + acc_n - ((mc != 0) ? 1 : 0);
      #1;
      check("count", 64'(count), 64'(mc));
   endtask

   // Present a request pair, retrying while the model says the FIFO is stalled.
   task automatic send(input logic av, input logic [4:0] ar, input logic [63:0] ad,
                       input logic lv, input logic [4:0] lr, input logic [63:0] ldat);
      int n;
      bit done = 0;
      alu_valid = av; alu_rd = ar; alu_data = ad;
      ld_valid  = lv; ld_rd  = lr; ld_data  = ldat;
      for (int g = 0; g < 10 && !done; g++) begin
         check("stall", 64'(stall), 64'(mc >= 3));
         if (mc < 3) begin
            n = 0;
            if (av && ar != XZR) begin sb.push_back('{rd: ar, data: ad}); n++; end
            if (lv && lr != XZR) begin sb.push_back('{rd: lr, data: ldat}); n++; end
            tick(n);
            done = 1;
         end else tick(0);
      end
      if (!done) check("send_timeout", 64'd0, 64'd1);
      alu_valid = 1'b0; ld_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && mc != 0; i++) tick(0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      foreach (rf[i]) rf[i] = '0;
      reset = 1'b1;
      alu_valid = 0; ld_valid = 0; alu_rd = 0; ld_rd = 0; alu_data = 0; ld_data = 0;
      ReadRegister1 = 5'd0; ReadRegister2 = 5'd31;
      #1;
      check("rst_we",    64'(RegWrite), 64'd0);
      check("rst_count", 64'(count), 64'd0);
      check("rst_stall", 64'(stall), 64'd0);
      check("rst_wdata", WriteData, 64'd0);
      check("rst_hit1",  64'(fwd_hit1), 64'd0);
      @(posedge clk); #2 reset = 1'b0;

      // 1. reset mid-operation with three entries queued
      send(1, 5'd20, 64'h20, 1, 5'd21, 64'h21);
      send(1, 5'd22, 64'h22, 1, 5'd23, 64'h23);
      check("t1_count3", 64'(count), 64'd3);
      #2 reset = 1'b1;
      #1;
      check("t1_we",    64'(RegWrite), 64'd0);
      check("t1_count", 64'(count), 64'd0);
      sb.delete(); mc = 0;
      @(posedge clk); #2 reset = 1'b0;
      for (int i = 0; i < 4; i++) tick(0);
      check("t1_we_after", 64'(RegWrite), 64'd0);

      // 2. single ALU write into empty FIFO
      send(1, 5'd5, 64'hA0, 0, 5'd0, 64'h0);
      check("t2_we",    64'(RegWrite), 64'd1);
      check("t2_wreg",  64'(WriteRegister), 64'd5);
      check("t2_wdata", WriteData, 64'hA0);
      tick(0);
      check("t2_rf5", rf[5], 64'hA0);

      // 3. dual request to the same register
      ReadRegister1 = 5'd3;
      send(1, 5'd3, 64'd1, 1, 5'd3, 64'd2);
      check("t3_hit1",   64'(fwd_hit1), 64'd1);
      check("t3_fwd1",   fwd_data1, 64'd2);
      check("t3_hit2",   64'(fwd_hit2), 64'd0);
      check("t3_fwd2",   fwd_data2, 64'd0);
      check("t3_wdata0", WriteData, 64'd1);
      tick(0);
      check("t3_fwd1_b", fwd_data1, 64'd2);
      check("t3_rf3_a",  rf[3], 64'd1);
      tick(0);
      check("t3_hit1_c", 64'(fwd_hit1), 64'd0);
      check("t3_rf3",    rf[3], 64'd2);

      // 4. XZR requests are dropped
      send(1, 5'd31, 64'hA0, 0, 5'd0, 64'h0);
      check("t4_we",   64'(RegWrite), 64'd0);
      check("t4_rf31", rf[31], 64'd0);

      // 5. fill with dual requests every cycle
      for (int r = 10; r < 18; r += 2)
         send(1, 5'(r), 64'h100 + 64'(r), 1, 5'(r + 1), 64'h100 + 64'(r + 1));
      ReadRegister1 = 5'd17; ReadRegister2 = 5'd4;
      #1;
      check("t5_hit1", 64'(fwd_hit1), 64'd1);
      check("t5_fwd1", fwd_data1, 64'h111);
      check("t5_hit2", 64'(fwd_hit2), 64'd0);
      drain();
      for (int r = 10; r < 18; r++) check("t5_rf", rf[r], 64'h100 + 64'(r));

      // 6. sequential singles wrapping the pointers
      for (int i = 1; i <= 10; i++)
         send(1, 5'(i), 64'(i) * 64'h0000010204080001, 0, 5'd0, 64'h0);
      drain();
      tick(0);
      for (int i = 1; i <= 10; i++) check("t6_rf", rf[i], 64'(i) * 64'h0000010204080001);
      check("t6_sb_empty", 64'(sb.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
